memory_access: RTL and testbench

//  Stage 4 of the multi-cycle MIPS datapath; sits directly upstream of write-back.

---
 rtl/mips_pkg.sv | 26 ++
 rtl/mem_lane_align.sv | 62 ++++++
 rtl/memory_access.sv | 174 +++++++++++++++++
 tb/tb_memory_access.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS multi-cycle datapath: access sizes, stage states
// and the alignment rule used by the memory-access stage.
package mips_pkg;

    localparam int DEST_W_DEF = 6;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] ST_IDLE     = 2'b00;
    localparam logic [1:0] ST_MEM_WAIT = 2'b01;
    localparam logic [1:0] ST_WB_HOLD  = 2'b10;

    // Size 2'b11 falls into the word rule.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = addr_lo[0];
            default: mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data bus: store enables/replicated data and
// load lane extraction with sign or zero extension (little-endian lanes).
module mem_lane_align
    import mips_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_unsigned,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_value
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_sign;

    // Store enables and lane-replicated write data.
    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_store_data;
        case (i_size)
            SZ_BYTE: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_store_data[7:0]}};
            end
            SZ_HALF: begin
                o_be    = 4'b0011 << i_addr_lo;
                o_wdata = {2{i_store_data[15:0]}};
            end
            default: begin
                o_be    = 4'b1111;
                o_wdata = i_store_data;
            end
        endcase
    end

    // Load lane extraction and extension.
    always_comb begin
        w_byte       = i_rdata[{i_addr_lo, 3'b000} +: 8];
        w_half       = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];
        w_sign       = 1'b0;
        o_load_value = i_rdata;
        case (i_size)
            SZ_BYTE: begin
                w_sign       = ~i_unsigned & w_byte[7];
                o_load_value = {{24{w_sign}}, w_byte};
            end
            SZ_HALF: begin
                w_sign       = ~i_unsigned & w_half[15];
                o_load_value = {{16{w_sign}}, w_half};
            end
            default: begin
                w_sign       = 1'b0;
                o_load_value = i_rdata;
            end
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// Memory-access stage: runs the data-memory load/store over a req/ack bus and
// hands {reg_write, address, value} to write-back through a valid/ready token.
module memory_access
    import mips_pkg::*;
#(
    parameter int DEST_W         = DEST_W_DEF,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_alu_result,
    input  logic [31:0]       in_store_data,
    input  logic [DEST_W-1:0] in_dest,
    input  logic              in_reg_write,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic [1:0]        in_size,
    input  logic              in_unsigned,
    output logic              mem_req,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic              wb_reg_write,
    output logic [DEST_W-1:0] wb_address,
    output logic [31:0]       wb_value,
    output logic              fault
);

    localparam int TCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]        r_state;
    logic [31:0]       r_alu;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic              r_mem_read;
    logic              r_reg_write;
    logic [TCNT_W-1:0] r_tcnt;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [31:0]       r_mem_addr;
    logic [3:0]        r_mem_be;
    logic [31:0]       r_mem_wdata;
    logic              r_wb_valid;
    logic              r_wb_reg_write;
    logic [DEST_W-1:0] r_wb_address;
    logic [31:0]       r_wb_value;
    logic              r_fault;

    logic              w_idle;
    logic [1:0]        w_sel_size;
    logic [1:0]        w_sel_addr;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [31:0]       w_load_value;
    logic              w_timeout;

    // In IDLE the aligner sees the incoming op (store lanes); afterwards the latched op (load lanes).
    assign w_idle     = (r_state == ST_IDLE);
    assign w_sel_size = w_idle ? in_size : r_size;
    assign w_sel_addr = w_idle ? in_alu_result[1:0] : r_alu[1:0];
    assign w_timeout  = (TIMEOUT_CYCLES != 0) && (r_tcnt == TCNT_LAST);

    mem_lane_align u_lane (
        .i_size       (w_sel_size),
        .i_addr_lo    (w_sel_addr),
        .i_unsigned   (r_unsigned),
        .i_store_data (in_store_data),
        .i_rdata      (mem_rdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_load_value (w_load_value)
    );

    // Stage FSM, bus request, timeout counter and write-back token.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_alu          <= 32'h0;
            r_size         <= 2'b00;
            r_unsigned     <= 1'b0;
            r_mem_read     <= 1'b0;
            r_reg_write    <= 1'b0;
            r_tcnt         <= '0;
            r_mem_req      <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= 32'h0;
            r_mem_be       <= 4'b0000;
            r_mem_wdata    <= 32'h0;
            r_wb_valid     <= 1'b0;
            r_wb_reg_write <= 1'b0;
            r_wb_address   <= '0;
            r_wb_value     <= 32'h0;
            r_fault        <= 1'b0;
        end else begin
            r_fault <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_alu        <= in_alu_result;
                        r_size       <= in_size;
                        r_unsigned   <= in_unsigned;
                        r_mem_read   <= in_mem_read;
                        r_reg_write  <= in_reg_write && (in_dest != {DEST_W{1'b0}});
                        r_wb_address <= in_dest;
                        r_wb_value   <= in_alu_result;
                        if (!in_mem_read && !in_mem_write) begin
                            r_wb_valid     <= 1'b1;
                            r_wb_reg_write <= in_reg_write && (in_dest != {DEST_W{1'b0}});
                            r_state        <= ST_WB_HOLD;
                        end else if (is_misaligned(in_size, in_alu_result[1:0])) begin
                            r_wb_valid     <= 1'b1;
                            r_wb_reg_write <= 1'b0;
                            r_fault        <= 1'b1;
                            r_state        <= ST_WB_HOLD;
                        end else begin
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= in_mem_write;
                            r_mem_addr  <= {in_alu_result[31:2], 2'b00};
                            r_mem_be    <= w_be;
                            r_mem_wdata <= w_wdata;
                            r_tcnt      <= '0;
                            r_state     <= ST_MEM_WAIT;
                        end
                    end
                end
                ST_MEM_WAIT: begin
                    if (mem_ack) begin
                        r_mem_req      <= 1'b0;
                        r_wb_valid     <= 1'b1;
                        r_wb_value     <= r_mem_read ? w_load_value : r_alu;
                        r_wb_reg_write <= r_reg_write;
                        r_state        <= ST_WB_HOLD;
                    end else if (w_timeout) begin
                        r_mem_req      <= 1'b0;
                        r_fault        <= 1'b1;
                        r_wb_valid     <= 1'b1;
                        r_wb_reg_write <= 1'b0;
                        r_state        <= ST_WB_HOLD;
                    end else begin
                        r_tcnt <= r_tcnt + TCNT_W'(1);
                    end
                end
                ST_WB_HOLD: begin
                    if (wb_ready) begin
                        r_wb_valid <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready     = w_idle;
    assign mem_req      = r_mem_req;
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_be       = r_mem_be;
    assign mem_wdata    = r_mem_wdata;
    assign wb_valid     = r_wb_valid;
    assign wb_reg_write = r_wb_reg_write;
    assign wb_address   = r_wb_address;
    assign wb_value     = r_wb_value;
    assign fault        = r_fault;

endmodule

// File: tb/tb_memory_access.sv
// Directed-vector bench for the memory-access stage with hand-computed expectations.
module tb_memory_access;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_alu_result = 32'h0;
    logic [31:0] in_store_data = 32'h0;
    logic [5:0]  in_dest = 6'd0;
    logic        in_reg_write = 1'b0;
    logic        in_mem_read = 1'b0;
    logic        in_mem_write = 1'b0;
    logic [1:0]  in_size = 2'b00;
    logic        in_unsigned = 1'b0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ack = 1'b0;
    logic        wb_valid;
    logic        wb_ready = 1'b1;
    logic        wb_reg_write;
    logic [5:0]  wb_address;
    logic [31:0] wb_value;
    logic        fault;

    int tests_run = 0;
    int tests_failed = 0;

    memory_access #(.DEST_W(6), .TIMEOUT_CYCLES(16)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_result(in_alu_result), .in_store_data(in_store_data),
        .in_dest(in_dest), .in_reg_write(in_reg_write),
        .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .in_size(in_size), .in_unsigned(in_unsigned),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_reg_write(wb_reg_write), .wb_address(wb_address),
        .wb_value(wb_value), .fault(fault)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [31:0] alu, input logic [31:0] sd, input logic [5:0] dest,
                         input logic rw, input logic mr, input logic mw,
                         input logic [1:0] sz, input logic uns);
        check("in_ready_before_issue", {31'h0, in_ready}, 32'h1);
        in_alu_result = alu;
        in_store_data = sd;
        in_dest       = dest;
        in_reg_write  = rw;
        in_mem_read   = mr;
        in_mem_write  = mw;
        in_size       = sz;
        in_unsigned   = uns;
        in_valid      = 1'b1;
        step();
        in_valid      = 1'b0;
        in_mem_read   = 1'b0;
        in_mem_write  = 1'b0;
    endtask

    task automatic ack_now(input logic [31:0] rdata);
        mem_rdata = rdata;
        mem_ack   = 1'b1;
        step();
        mem_ack   = 1'b0;
    endtask

    logic [31:0] held_value;

    initial begin
        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst_in_ready", {31'h0, in_ready}, 32'h1);
        check("rst_mem_req",  {31'h0, mem_req},  32'h0);
        check("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
        check("rst_fault",    {31'h0, fault},    32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        step();

        // ALU pass-through
        issue(32'h0000_1234, 32'h0, 6'd5, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
        check("alu_wb_valid", {31'h0, wb_valid}, 32'h1);
        check("alu_value",    wb_value, 32'h0000_1234);
        check("alu_regwrite", {31'h0, wb_reg_write}, 32'h1);
        check("alu_addr",     {26'h0, wb_address}, 32'd5);
        check("alu_in_ready", {31'h0, in_ready}, 32'h0);
        step();
        check("alu_wb_drop",  {31'h0, wb_valid}, 32'h0);

        // dest == $zero suppresses reg_write
        issue(32'h0000_0055, 32'h0, 6'd0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
        check("zero_dest_regwrite", {31'h0, wb_reg_write}, 32'h0);
        step();

        // lb 0x103, ack after 3 cycles
        issue(32'h0000_0103, 32'h0, 6'd7, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
        check("lb_req",  {31'h0, mem_req}, 32'h1);
        check("lb_we",   {31'h0, mem_we},  32'h0);
        check("lb_addr", mem_addr, 32'h0000_0100);
        check("lb_be",   {28'h0, mem_be}, 32'h8);
        step();
        step();
        check("lb_req_held", {31'h0, mem_req}, 32'h1);
        ack_now(32'h80FF_FF7F);
        check("lb_req_drop", {31'h0, mem_req}, 32'h0);
        check("lb_value",    wb_value, 32'hFFFF_FF80);
        check("lb_regwrite", {31'h0, wb_reg_write}, 32'h1);
        step();

        // lbu 0x103
        issue(32'h0000_0103, 32'h0, 6'd7, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1);
        ack_now(32'h80FF_FF7F);
        check("lbu_value", wb_value, 32'h0000_0080);
        step();

        // lh 0x102, upper half signed
        issue(32'h0000_0102, 32'h0, 6'd8, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0);
        ack_now(32'h8001_7FFF);
        check("lh_value", wb_value, 32'hFFFF_8001);
        step();

        // sh 0x202
        issue(32'h0000_0202, 32'h0000_ABCD, 6'd0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
        check("sh_we",    {31'h0, mem_we}, 32'h1);
        check("sh_addr",  mem_addr, 32'h0000_0200);
        check("sh_be",    {28'h0, mem_be}, 32'hC);
        check("sh_wdata", mem_wdata, 32'hABCD_ABCD);
        ack_now(32'h0);
        check("sh_regwrite", {31'h0, wb_reg_write}, 32'h0);
        step();

        // sb 0x101
        issue(32'h0000_0101, 32'h1234_565A, 6'd0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
        check("sb_be",    {28'h0, mem_be}, 32'h2);
        check("sb_wdata", mem_wdata, 32'h5A5A_5A5A);
        ack_now(32'h0);
        step();

        // Misaligned lw 0x101
        issue(32'h0000_0101, 32'h0, 6'd3, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
        check("mis_req",      {31'h0, mem_req}, 32'h0);
        check("mis_fault",    {31'h0, fault}, 32'h1);
        check("mis_wb_valid", {31'h0, wb_valid}, 32'h1);
        check("mis_regwrite", {31'h0, wb_reg_write}, 32'h0);
        step();
        check("mis_fault_pulse", {31'h0, fault}, 32'h0);

        // Ack outside MEM_WAIT is ignored
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("stray_ack_wb", {31'h0, wb_valid}, 32'h0);
        check("stray_ack_ready", {31'h0, in_ready}, 32'h1);

        // Timeout with write-back back-pressure
        wb_ready = 1'b0;
        issue(32'h0000_0300, 32'h0, 6'd4, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
        repeat (15) step();
        check("to_req_before", {31'h0, mem_req}, 32'h1);
        step();
        check("to_req_drop",  {31'h0, mem_req}, 32'h0);
        check("to_fault",     {31'h0, fault}, 32'h1);
        check("to_wb_valid",  {31'h0, wb_valid}, 32'h1);
        check("to_regwrite",  {31'h0, wb_reg_write}, 32'h0);
        held_value = 32'h0000_0300;
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_valid", {31'h0, wb_valid}, 32'h1);
            check("hold_value", wb_value, held_value);
            check("hold_addr",  {26'h0, wb_address}, 32'd4);
        end
        check("to_fault_pulse", {31'h0, fault}, 32'h0);
        wb_ready = 1'b1;
        step();
        check("hold_release", {31'h0, wb_valid}, 32'h0);

        // Ack on the timeout cycle wins
        issue(32'h0000_0400, 32'h0, 6'd9, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
        repeat (15) step();
        ack_now(32'h1122_3344);
        check("ackto_fault",    {31'h0, fault}, 32'h0);
        check("ackto_value",    wb_value, 32'h1122_3344);
        check("ackto_regwrite", {31'h0, wb_reg_write}, 32'h1);
        step();

        // Async reset mid-transaction
        issue(32'h0000_0500, 32'h0, 6'd2, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
        check("ar_req_up", {31'h0, mem_req}, 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_req_drop",  {31'h0, mem_req}, 32'h0);
        check("ar_wb_valid",  {31'h0, wb_valid}, 32'h0);
        check("ar_in_ready",  {31'h0, in_ready}, 32'h1);
        @(negedge clock);
        reset_n = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
